// File: rtl/n101_icache_ram_bank.sv
// Per-way tag/data SRAM bank for the n101 icache with held read data and a
// tag-invalidation sweep that runs after reset and on flush request.
module n101_icache_ram_bank #(
   parameter int NWAYS   = 2,
   parameter int TAG_AW  = 6,
   parameter int TAG_DW  = 22,
   parameter int DATA_AW = 8,
   parameter int DATA_DW = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NWAYS-1:0]           tag_cs_i,
   input  logic [NWAYS-1:0]           tag_we_i,
   input  logic [TAG_AW-1:0]          tag_addr_i,
   input  logic [TAG_DW-1:0]          tag_wdata_i,
   output logic [NWAYS*TAG_DW-1:0]    tag_rdata_o,
   input  logic [NWAYS-1:0]           data_cs_i,
   input  logic [NWAYS-1:0]           data_we_i,
   input  logic [DATA_AW-1:0]         data_addr_i,
   input  logic [DATA_DW-1:0]         data_wdata_i,
   output logic [NWAYS*DATA_DW-1:0]   data_rdata_o,
   input  logic                       flush_req_i,
   output logic                       inv_busy_o,
   output logic                       inv_done_o
);

   localparam int TAG_DEPTH  = 2**TAG_AW;
   localparam int DATA_DEPTH = 2**DATA_AW;
   localparam logic [TAG_AW:0] LAST_IDX = (TAG_AW+1)'(TAG_DEPTH - 1);

   typedef enum logic {
      ST_SWEEP,
      ST_IDLE
   } state_e;

   state_e          state_q, state_d;
   logic [TAG_AW:0] idx_q, idx_d;
   logic            inv_done_q, inv_done_d;
   logic            acc_en;
   logic            sweep_wr;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      inv_done_d = 1'b0;
      acc_en     = 1'b0;
      case (state_q)
         ST_SWEEP: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d    = ST_IDLE;
               idx_d      = '0;
               inv_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            // The flush cycle itself is not an access cycle.
            if (flush_req_i) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
            end else begin
               acc_en = 1'b1;
            end
         end
         default: state_d = ST_SWEEP;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_SWEEP;
         idx_q      <= '0;
         inv_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         inv_done_q <= inv_done_d;
      end
   end

   assign inv_busy_o = (state_q == ST_SWEEP);
   assign inv_done_o = inv_done_q;
   assign sweep_wr   = !rst && (state_q == ST_SWEEP);

   for (genvar w = 0; w < NWAYS; w++) begin : g_way
      logic [TAG_DW-1:0]  tag_mem  [TAG_DEPTH];
      logic [DATA_DW-1:0] data_mem [DATA_DEPTH];
      logic [TAG_DW-1:0]  tag_rd_q;
      logic [DATA_DW-1:0] data_rd_q;
      logic               tag_acc, data_acc;

      assign tag_acc  = !rst && acc_en && tag_cs_i[w];
      assign data_acc = !rst && acc_en && data_cs_i[w];

      // NOTE: the arrays have no reset; they model SRAM macros whose contents
      // are undefined at power-up, and only the tags are cleared by the sweep.
      always_ff @(posedge clk) begin
         if (sweep_wr) begin
            tag_mem[idx_q[TAG_AW-1:0]] <= '0;
         end else if (tag_acc && tag_we_i[w]) begin
            tag_mem[tag_addr_i] <= tag_wdata_i;
         end
         if (data_acc && data_we_i[w]) begin
            data_mem[data_addr_i] <= data_wdata_i;
         end
      end

      // Read data is held until the next read of this way; writes do not update it.
      always_ff @(posedge clk) begin
         if (rst) begin
            tag_rd_q  <= '0;
            data_rd_q <= '0;
         end else begin
            if (tag_acc && !tag_we_i[w]) begin
               tag_rd_q <= tag_mem[tag_addr_i];
            end
            if (data_acc && !data_we_i[w]) begin
               data_rd_q <= data_mem[data_addr_i];
            end
         end
      end

      assign tag_rdata_o[w*TAG_DW +: TAG_DW]    = tag_rd_q;
      assign data_rdata_o[w*DATA_DW +: DATA_DW] = data_rd_q;
   end

endmodule

// File: tb/tb_n101_icache_ram_bank.sv
// Self-checking bench for n101_icache_ram_bank (NWAYS=2, TAG_AW=4): directed
// vector table, sweep timing sequences and randomized traffic against a model.
module tb_n101_icache_ram_bank;

   localparam int NW   = 2;
   localparam int TAW  = 4;
   localparam int TDW  = 22;
   localparam int DAW  = 8;
   localparam int DDW  = 32;
   localparam int TDEP = 16;

   logic                 clk;
   logic                 rst;
   logic [NW-1:0]        tag_cs, tag_we, data_cs, data_we;
   logic [TAW-1:0]       tag_addr;
   logic [TDW-1:0]       tag_wdata;
   logic [NW*TDW-1:0]    tag_rdata;
   logic [DAW-1:0]       data_addr;
   logic [DDW-1:0]       data_wdata;
   logic [NW*DDW-1:0]    data_rdata;
   logic                 flush_req, inv_busy, inv_done;

   n101_icache_ram_bank #(
      .NWAYS(NW), .TAG_AW(TAW), .TAG_DW(TDW), .DATA_AW(DAW), .DATA_DW(DDW)
   ) dut (
      .clk(clk), .rst(rst),
      .tag_cs_i(tag_cs), .tag_we_i(tag_we), .tag_addr_i(tag_addr),
      .tag_wdata_i(tag_wdata), .tag_rdata_o(tag_rdata),
      .data_cs_i(data_cs), .data_we_i(data_we), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
      .flush_req_i(flush_req), .inv_busy_o(inv_busy), .inv_done_o(inv_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a countdown of remaining sweep cycles; tags vanish when it ends.
   int               sweep_left = 0;
   logic             m_done = 1'b0;
   logic [TDW-1:0]   m_tag  [NW][TDEP];
   logic [DDW-1:0]   m_data [NW][256];
   logic [TDW-1:0]   m_trd  [NW];
   logic [DDW-1:0]   m_drd  [NW];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         sweep_left = TDEP;
         m_done     = 1'b0;
         for (int w = 0; w < NW; w++) begin
            m_trd[w] = '0;
            m_drd[w] = '0;
         end
      end else if (sweep_left > 0) begin
         sweep_left--;
         m_done = (sweep_left == 0);
         if (sweep_left == 0) begin
            for (int w = 0; w < NW; w++)
               for (int i = 0; i < TDEP; i++) m_tag[w][i] = '0;
         end
      end else begin
         m_done = 1'b0;
         if (flush_req) begin
            sweep_left = TDEP;
         end else begin
            for (int w = 0; w < NW; w++) begin
               if (tag_cs[w] && !tag_we[w]) m_trd[w] = m_tag[w][tag_addr];
               if (tag_cs[w] && tag_we[w])  m_tag[w][tag_addr] = tag_wdata;
               if (data_cs[w] && !data_we[w]) m_drd[w] = m_data[w][data_addr];
               if (data_cs[w] && data_we[w])  m_data[w][data_addr] = data_wdata;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic fl,
                        input logic [1:0] tcs, input logic [1:0] twe,
                        input logic [3:0] ta, input logic [21:0] twd,
                        input logic [1:0] dcs, input logic [1:0] dwe,
                        input logic [7:0] da, input logic [31:0] dwd);
      rst = r; flush_req = fl;
      tag_cs = tcs; tag_we = twe; tag_addr = ta; tag_wdata = twd;
      data_cs = dcs; data_we = dwe; data_addr = da; data_wdata = dwd;
      @(posedge clk);
      model_step();
      #1;
      check("busy", 64'(inv_busy), 64'(sweep_left > 0));
      check("done", 64'(inv_done), 64'(m_done));
      check("tag_rdata", 64'(tag_rdata), 64'({m_trd[1], m_trd[0]}));
      check("data_rdata", data_rdata, {m_drd[1], m_drd[0]});
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
   endtask

   // Runs a sweep whose first busy sample has just been taken; counts busy
   // samples and inv_done pulses with that sample numbered 1.
   task automatic measure_sweep(input logic [1:0] tcs, input logic [1:0] twe,
                                input logic [21:0] twd, input int flush_at,
                                input int rst_at, output int busy_cnt,
                                output int done_at, output int done_cnt);
      logic [1:0] cs_eff;
      busy_cnt = inv_busy ? 1 : 0;
      done_cnt = inv_done ? 1 : 0;
      done_at  = 0;
      for (int pos = 2; pos <= 40; pos++) begin
         cs_eff = inv_busy ? tcs : 2'b00;
         cycle(pos - 1 == rst_at, pos - 1 == flush_at, cs_eff, cs_eff & twe,
               4'(pos), twd, 2'b00, 2'b00, 8'h00, '0);
         if (inv_busy) busy_cnt++;
         if (inv_done) begin
            done_cnt++;
            done_at = pos;
         end
      end
   endtask

   task automatic read_all_tags_zero();
      for (int i = 0; i < TDEP; i++) begin
         cycle(1'b0, 1'b0, 2'b11, 2'b00, 4'(i), '0, 2'b00, 2'b00, 8'h00, '0);
         check($sformatf("tag_zero[%0d]", i), 64'(tag_rdata), 64'd0);
      end
   endtask

   typedef struct {
      logic [1:0]  tcs, twe;
      logic [3:0]  ta;
      logic [21:0] twd;
      logic [1:0]  dcs, dwe;
      logic [7:0]  da;
      logic [31:0] dwd;
      logic [43:0] exp_trd;
      logic [63:0] exp_drd;
   } vec_t;

   function automatic vec_t mk(logic [1:0] tcs, logic [1:0] twe, logic [3:0] ta,
                               logic [21:0] twd, logic [1:0] dcs, logic [1:0] dwe,
                               logic [7:0] da, logic [31:0] dwd,
                               logic [43:0] et, logic [63:0] ed);
      vec_t v;
      v.tcs = tcs; v.twe = twe; v.ta = ta; v.twd = twd;
      v.dcs = dcs; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.exp_trd = et; v.exp_drd = ed;
      return v;
   endfunction

   vec_t vecs[14];

   initial begin
      int busy_cnt, done_at, done_cnt;
      logic [43:0] t5;
      logic [63:0] dbe;
      logic [1:0]  rcs, rwe, rdcs, rdwe;
      for (int w = 0; w < NW; w++) begin
         for (int i = 0; i < TDEP; i++) m_tag[w][i] = '0;
         for (int i = 0; i < 256; i++)  m_data[w][i] = '0;
         m_trd[w] = '0;
         m_drd[w] = '0;
      end
      rst = 1'b1; flush_req = 1'b0;
      tag_cs = '0; tag_we = '0; tag_addr = '0; tag_wdata = '0;
      data_cs = '0; data_we = '0; data_addr = '0; data_wdata = '0;

      // Reset and the power-up sweep.
      cycle(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
      cycle(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
      check("reset_busy", 64'(inv_busy), 64'd1);
      check("reset_done", 64'(inv_done), 64'd0);
      check("reset_tag_rdata", 64'(tag_rdata), 64'd0);
      check("reset_data_rdata", data_rdata, 64'd0);
      measure_sweep(2'b00, 2'b00, '0, 0, 0, busy_cnt, done_at, done_cnt);
      check("por_busy_cycles", 64'(busy_cnt), 64'd16);
      check("por_done_cycle", 64'(done_at), 64'd17);
      check("por_done_count", 64'(done_cnt), 64'd1);
      read_all_tags_zero();
      cycle(1'b0, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
      check("tag_rd_held_zero", 64'(tag_rdata), 64'd0);

      // Directed IDLE vectors; expected values are after each row's clock edge.
      t5  = {22'h2AAAA1, 22'h0};
      dbe = {32'h0, 32'hDEADBEEF};
      vecs[0]  = mk(2'b10, 2'b10, 4'd5, 22'h2AAAA1, 2'b00, 2'b00, 8'h00, 32'h0, 44'h0, 64'h0);
      vecs[1]  = mk(2'b10, 2'b00, 4'd5, 22'h0, 2'b00, 2'b00, 8'h00, 32'h0, t5, 64'h0);
      vecs[2]  = mk(2'b01, 2'b00, 4'd5, 22'h0, 2'b00, 2'b00, 8'h00, 32'h0, t5, 64'h0);
      vecs[3]  = mk(2'b00, 2'b00, 4'd0, 22'h0, 2'b01, 2'b01, 8'h3C, 32'hDEADBEEF, t5, 64'h0);
      vecs[4]  = mk(2'b00, 2'b00, 4'd0, 22'h0, 2'b01, 2'b00, 8'h3C, 32'h0, t5, dbe);
      for (int i = 5; i < 10; i++)
         vecs[i] = mk(2'b00, 2'b00, 4'd0, 22'h0, 2'b00, 2'b00, 8'h00, 32'h0, t5, dbe);
      vecs[10] = mk(2'b11, 2'b11, 4'd3, 22'h15, 2'b00, 2'b00, 8'h00, 32'h0, t5, dbe);
      vecs[11] = mk(2'b11, 2'b00, 4'd3, 22'h0, 2'b00, 2'b00, 8'h00, 32'h0,
                    {22'h15, 22'h15}, dbe);
      vecs[12] = mk(2'b00, 2'b11, 4'd3, 22'h3FFFFF, 2'b00, 2'b00, 8'h00, 32'h0,
                    {22'h15, 22'h15}, dbe);
      vecs[13] = mk(2'b11, 2'b00, 4'd3, 22'h0, 2'b00, 2'b00, 8'h00, 32'h0,
                    {22'h15, 22'h15}, dbe);
      for (int i = 0; i < 14; i++) begin
         cycle(1'b0, 1'b0, vecs[i].tcs, vecs[i].twe, vecs[i].ta, vecs[i].twd,
               vecs[i].dcs, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
         check($sformatf("vec%0d_tag", i), 64'(tag_rdata), 64'(vecs[i].exp_trd));
         check($sformatf("vec%0d_data", i), data_rdata, vecs[i].exp_drd);
      end

      // Known contents for the random data window, then random traffic.
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b11, 2'b11, 8'(i), $urandom);
      for (int n = 0; n < 300; n++) begin
         rcs = 2'($urandom); rwe = 2'($urandom);
         rdcs = 2'($urandom); rdwe = 2'($urandom);
         cycle(1'b0, $urandom_range(0, 49) == 0, rcs, rwe, 4'($urandom), 22'($urandom),
               rdcs, rdwe, 8'($urandom_range(0, 15)), $urandom);
      end
      for (int n = 0; n < 20; n++) idle();

      // Flush with nonzero tags, writes and a second flush during the sweep.
      for (int i = 0; i < TDEP; i++)
         cycle(1'b0, 1'b0, 2'b11, 2'b11, 4'(i), 22'(i + 1), 2'b00, 2'b00, 8'h00, '0);
      cycle(1'b0, 1'b1, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
      measure_sweep(2'b11, 2'b11, 22'hFFFF, 5, 0, busy_cnt, done_at, done_cnt);
      check("flush_busy_cycles", 64'(busy_cnt), 64'd16);
      check("flush_done_cycle", 64'(done_at), 64'd17);
      check("flush_done_count", 64'(done_cnt), 64'd1);
      read_all_tags_zero();
      cycle(1'b0, 1'b0, 2'b00, 2'b00, 4'h0, '0, 2'b01, 2'b00, 8'h3C, '0);
      check("data_intact", 64'(data_rdata[31:0]), 64'h0000_0000_DEADBEEF);

      // Reset while the sweep is at index 7.
      cycle(1'b0, 1'b1, 2'b00, 2'b00, 4'h0, '0, 2'b00, 2'b00, 8'h00, '0);
      measure_sweep(2'b00, 2'b00, '0, 0, 8, busy_cnt, done_at, done_cnt);
      check("rst_sweep_busy_cycles", 64'(busy_cnt), 64'd24);
      check("rst_sweep_done_cycle", 64'(done_at), 64'd25);
      check("rst_sweep_done_count", 64'(done_cnt), 64'd1);
      read_all_tags_zero();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
